// File: rtl/packet_framer_tx.sv
// Transmit framer: start word, time stamp, NUM_CH zero-extended 12-bit samples,
// with K28.5 comma idles between packets and during upstream stalls.
`timescale 1ns/1ps

module packet_framer_tx #(
    parameter int          NUM_CH   = 125,
    parameter int          IDLE_GAP = 4,
    parameter logic [15:0] K_IDLE   = 16'hBCBC
) (
    input  logic        rx_std_clkout,
    input  logic        rst_n,
    input  logic        link_up,
    input  logic        frame_start,
    input  logic [11:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_datak,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [7:0]  drop_count
);

    localparam logic [15:0] START_WORD = 16'hFFFF;
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_CH - 1);
    localparam logic [7:0]  GAP_LOAD   = 8'(IDLE_GAP);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STAMP   = 2'd1,
        S_PAYLOAD = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ts_q;
    logic [15:0] stamp_q, stamp_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [15:0] tx_data_d;
    logic [1:0]  tx_datak_d;
    logic        busy_d;
    logic        done_d;
    logic        abort_d;
    logic [7:0]  drop_d;
    logic        accept;

    // Handshake: a sample transfers on an edge where sample_valid and
    // sample_ready are both high; sample_data must hold while valid waits.
    assign sample_ready = (state_q == S_PAYLOAD) && link_up;

    always_ff @(posedge rx_std_clkout) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ts_q        <= 16'h0000;
            stamp_q     <= 16'h0000;
            gap_q       <= 8'h00;
            pcnt_q      <= 8'h00;
            tx_data     <= K_IDLE;
            tx_datak    <= 2'b11;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            drop_count  <= 8'h00;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + 16'd1;
            stamp_q     <= stamp_d;
            gap_q       <= gap_d;
            pcnt_q      <= pcnt_d;
            tx_data     <= tx_data_d;
            tx_datak    <= tx_datak_d;
            busy        <= busy_d;
            frame_done  <= done_d;
            frame_abort <= abort_d;
            drop_count  <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stamp_d    = stamp_q;
        gap_d      = gap_q;
        pcnt_d     = pcnt_q;
        tx_data_d  = K_IDLE;
        tx_datak_d = 2'b11;
        busy_d     = busy;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start && link_up && (gap_q == 8'h00)) begin
                    accept     = 1'b1;
                    stamp_d    = ts_q;
                    tx_data_d  = START_WORD;
                    tx_datak_d = 2'b00;
                    pcnt_d     = 8'h00;
                    busy_d     = 1'b1;
                    state_d    = S_STAMP;
                end else if (gap_q != 8'h00) begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_STAMP: begin
                if (!link_up) begin
                    abort_d = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    tx_data_d  = stamp_q;
                    tx_datak_d = 2'b00;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // Loss of link wins over a pending sample, which stays upstream.
                if (!link_up) begin
                    abort_d = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else if (sample_valid) begin
                    tx_data_d  = {4'h0, sample_data};
                    tx_datak_d = 2'b00;
                    pcnt_d     = pcnt_q + 8'd1;
                    if (pcnt_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= 8'd1) begin
                    gap_d   = 8'h00;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drop_d = drop_count;
        if (frame_start && !accept && (drop_count != 8'hFF)) begin
            drop_d = drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_packet_framer_tx.sv
// Bench for packet_framer_tx: default instance plus a NUM_CH=3 / IDLE_GAP=1 instance,
// scoreboard of expected {tx_data, tx_datak, frame_done, frame_abort} per clock.
`timescale 1ns/1ps

module tb_packet_framer_tx;

    logic        clk;
    logic        rst_n;
    logic        link_up;
    logic        frame_start;
    logic        frame_start_b;
    logic [11:0] sample_data;
    logic        sample_valid;

    logic        sample_ready,  sample_ready_b;
    logic [15:0] tx_data,       tx_data_b;
    logic [1:0]  tx_datak,      tx_datak_b;
    logic        busy,          busy_b;
    logic        frame_done,    frame_done_b;
    logic        frame_abort,   frame_abort_b;
    logic [7:0]  drop_count,    drop_count_b;

    int          vectors;
    int          miscompares;
    logic [15:0] ts_model;
    logic        mon_sel;
    logic [19:0] exp_q[$];

    localparam logic [19:0] KW = {16'hBCBC, 2'b11, 1'b0, 1'b0};

    packet_framer_tx dut_a (
        .rx_std_clkout(clk),
        .rst_n(rst_n),
        .link_up(link_up),
        .frame_start(frame_start),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .tx_data(tx_data),
        .tx_datak(tx_datak),
        .busy(busy),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
        .drop_count(drop_count)
    );

    packet_framer_tx #(.NUM_CH(3), .IDLE_GAP(1)) dut_b (
        .rx_std_clkout(clk),
        .rst_n(rst_n),
        .link_up(link_up),
        .frame_start(frame_start_b),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready_b),
        .tx_data(tx_data_b),
        .tx_datak(tx_datak_b),
        .busy(busy_b),
        .frame_done(frame_done_b),
        .frame_abort(frame_abort_b),
        .drop_count(drop_count_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: one expected word per clock edge, compared mid-cycle
    always @(negedge clk) begin
        logic [19:0] got;
        logic [19:0] exp_w;
        if (exp_q.size() > 0) begin
            got   = mon_sel ? {tx_data_b, tx_datak_b, frame_done_b, frame_abort_b}
                            : {tx_data, tx_datak, frame_done, frame_abort};
            exp_w = exp_q.pop_front();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL sb_word t=%0t dut=%s got data=%h k=%b done=%b abort=%b exp data=%h k=%b done=%b abort=%b",
                         $time, mon_sel ? "b" : "a", got[19:4], got[3:2], got[1], got[0],
                         exp_w[19:4], exp_w[3:2], exp_w[1], exp_w[0]);
            end
        end
    end

    function automatic logic [19:0] ent(input logic [15:0] d, input logic [1:0] k,
                                        input logic done, input logic abort);
        return {d, k, done, abort};
    endfunction

    // driver: queue the word the next edge must produce, then advance one clock
    task automatic tick(input logic [19:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        ts_model = rst_n ? ts_model + 16'd1 : 16'h0000;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; link_up = 1'b1; frame_start = 1'b0; frame_start_b = 1'b0;
        sample_valid = 1'b0; sample_data = 12'h000;
        for (int i = 0; i < 3; i++) tick(KW);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (drop_count !== 8'h00) begin miscompares++; $display("FAIL reset_drop got %h exp 00", drop_count); end
        vectors++; if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", sample_ready); end
        vectors++; if (tx_data_b !== 16'hBCBC || tx_datak_b !== 2'b11) begin miscompares++; $display("FAIL reset_b_tx got %h/%b exp bcbc/11", tx_data_b, tx_datak_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_packet();
        while (ts_model != 16'h0010) tick(KW);
        frame_start = 1'b1;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        frame_start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_start got %b exp 1", busy); end
        tick(ent(16'h0010, 2'b00, 1'b0, 1'b0));
        vectors++; if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready got %b exp 1", sample_ready); end
        sample_valid = 1'b1;
        for (int i = 0; i < 125; i++) begin
            sample_data = 12'(i);
            tick(ent(16'(i), 2'b00, i == 124, 1'b0));
        end
        sample_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_gap%0d got %b exp 1", g, busy); end
            tick(KW);
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_stall();
        logic [15:0] stamp;
        logic [11:0] sd;
        stamp = ts_model;
        frame_start = 1'b1;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        frame_start = 1'b0;
        tick(ent(stamp, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < 125; i++) begin
            if (i == 11) begin
                for (int s = 0; s < 3; s++) begin
                    sample_valid = 1'b0;
                    tick(KW);
                    vectors++; if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready%0d got %b exp 1", s, sample_ready); end
                end
            end
            sd = (i == 10) ? 12'h00A : (i == 11) ? 12'h00B : 12'($urandom_range(0, 4095));
            sample_valid = 1'b1;
            sample_data  = sd;
            tick(ent({4'h0, sd}, 2'b00, i == 124, 1'b0));
        end
        sample_valid = 1'b0;
        for (int g = 0; g < 4; g++) tick(KW);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_drop();
        logic [15:0] stamp;
        stamp = ts_model;
        frame_start = 1'b1;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        frame_start = 1'b0;
        tick(ent(stamp, 2'b00, 1'b0, 1'b0));
        sample_valid = 1'b1;
        for (int i = 0; i < 125; i++) begin
            sample_data = 12'(i + 7);
            frame_start = (i == 20);
            tick(ent(16'(i + 7), 2'b00, i == 124, 1'b0));
        end
        sample_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            frame_start = (g == 3);
            tick(KW);
        end
        frame_start = 1'b0;
        tick(KW);
        tick(KW);
        vectors++; if (drop_count !== 8'd2) begin miscompares++; $display("FAIL drop_two got %0d exp 2", drop_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_busy got %b exp 0", busy); end
        link_up = 1'b0;
        frame_start = 1'b1;
        for (int n = 0; n < 256; n++) begin
            tick(KW);
            if (n == 99) begin
                vectors++; if (drop_count !== 8'd102) begin miscompares++; $display("FAIL drop_mid got %0d exp 102", drop_count); end
            end
        end
        vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL drop_sat got %0d exp 255", drop_count); end
        frame_start = 1'b0;
        link_up = 1'b1;
        tick(KW);
    endtask

    task automatic test_abort();
        logic [15:0] stamp;
        stamp = ts_model;
        frame_start = 1'b1;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        frame_start = 1'b0;
        tick(ent(stamp, 2'b00, 1'b0, 1'b0));
        sample_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sample_data = 12'(3 * i);
            tick(ent(16'(3 * i), 2'b00, 1'b0, 1'b0));
        end
        link_up = 1'b0;
        sample_data = 12'h123;
        tick(ent(16'hBCBC, 2'b11, 1'b0, 1'b1));
        vectors++; if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b exp 0", sample_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy got %b exp 1", busy); end
        tick(KW);
        link_up = 1'b1;
        tick(KW);
        frame_start = 1'b1;
        tick(KW);
        frame_start = 1'b0;
        tick(KW);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_gap_end got %b exp 0", busy); end
        stamp = ts_model;
        frame_start = 1'b1;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        frame_start = 1'b0;
        tick(ent(stamp, 2'b00, 1'b0, 1'b0));
        sample_data = 12'h055;
        tick(ent(16'h0055, 2'b00, 1'b0, 1'b0));
        rst_n = 1'b0;
        tick(KW);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b exp 0", busy); end
        vectors++; if (drop_count !== 8'h00) begin miscompares++; $display("FAIL midreset_drop got %0d exp 0", drop_count); end
        vectors++; if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready got %b exp 0", sample_ready); end
        rst_n = 1'b1;
        sample_valid = 1'b0;
    endtask

    task automatic test_wrap();
        while (ts_model != 16'hFFFF) tick(KW);
        frame_start = 1'b1;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        frame_start = 1'b0;
        tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
        sample_valid = 1'b1;
        sample_data  = 12'hFFF;
        for (int i = 0; i < 125; i++) tick(ent(16'h0FFF, 2'b00, i == 124, 1'b0));
        sample_valid = 1'b0;
        for (int g = 0; g < 4; g++) tick(KW);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stamp;
        logic [11:0] sd;
        mon_sel = 1'b1;
        frame_start_b = 1'b1;
        sample_valid  = 1'b1;
        for (int p = 0; p < 3; p++) begin
            stamp = ts_model;
            tick(ent(16'hFFFF, 2'b00, 1'b0, 1'b0));
            tick(ent(stamp, 2'b00, 1'b0, 1'b0));
            for (int i = 0; i < 3; i++) begin
                sd = 12'($urandom_range(0, 4095));
                sample_data = sd;
                tick(ent({4'h0, sd}, 2'b00, i == 2, 1'b0));
            end
            tick(KW);
        end
        frame_start_b = 1'b0;
        sample_valid  = 1'b0;
        vectors++; if (drop_count_b !== 8'd15) begin miscompares++; $display("FAIL b2b_drop got %0d exp 15", drop_count_b); end
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got %b exp 0", busy_b); end
        tick(KW);
        mon_sel = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        ts_model = 16'h0000;
        mon_sel = 1'b0;
        test_reset();
        test_basic_packet();
        test_stall();
        test_drop();
        test_abort();
        test_back_to_back();
        test_wrap();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got %0d exp 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
